instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising edge); reset input 1 (synchronous, active-low, 0 = reset).
REQ-002 in_valid input 1 SHALL mean an encode request is present.
REQ-003 in_ready output 1 SHALL mean the block can accept a request this cycle.
REQ-004 in_type input 8 SHALL carry the instruction code, using the shared instr_type encoding: add=0x80, sub=0x81, ori=0x82, lui=0x83, lw=0x84, sw=0x85, beq=0x86, jal=0x87, jr=0x88, nop=0x89.
REQ-005 in_rs input 5, in_rt input 5 and in_rd input 5 SHALL carry the register fields.
REQ-006 in_imm input 16 SHALL carry the I-type immediate.
REQ-007 in_target input 26 SHALL carry the J-type target.
REQ-008 im_we output 1 SHALL mean a word write to instruction memory is pending.
REQ-009 im_ready input 1 SHALL mean instruction memory accepts the pending write this cycle.
REQ-010 im_addr output 32 SHALL carry the byte address of the pending write.
REQ-011 im_wdata output 32 SHALL carry the encoded machine word.
REQ-012 clear input 1 SHALL restart the address counter.
REQ-013 full output 1 SHALL mean capacity is reached.
REQ-014 err output 1 SHALL be a sticky flag meaning an unknown in_type was received.
REQ-015 count output 11 SHALL give the number of words written.

Function
REQ-016 A request SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-017 Encoding SHALL be: add = {000000,rs,rt,rd,00000,100000}; sub = {000000,rs,rt,rd,00000,100010}; ori = {001101,rs,rt,imm}; lui = {001111,00000,rt,imm}; lw = {100011,rs,rt,imm}; sw = {101011,rs,rt,imm}; beq = {000100,rs,rt,imm}; jal = {000011,target}; jr = {000000,rs,15'b0,001000}; nop = 32'h0.
REQ-018 Latency SHALL be one cycle: a request accepted at edge N drives im_we=1 with its word after edge N.
REQ-019 im_we, im_addr and im_wdata SHALL be registered and held stable until im_ready=1.
REQ-020 A write SHALL complete on a cycle with im_we=1 and im_ready=1; on that edge im_addr SHALL advance by 4 and count SHALL increment by 1.
REQ-021 in_ready SHALL equal (!im_we || im_ready) && state!=FULL && !clear, so back-to-back writes sustain one word per cycle when im_ready stays 1.
REQ-022 An unknown in_type SHALL be accepted but not written: err is set, and im_we, im_addr and count are unaffected.
REQ-023 The FSM SHALL have states IDLE (count=0), RUN and FULL.
REQ-024 FSM transitions SHALL be: IDLE->RUN on the first completed write; RUN->FULL when count reaches 1024; any state->IDLE on clear.
REQ-025 In FULL, full SHALL be 1 and in_ready SHALL be 0.
REQ-026 clear=1 SHALL, on the next edge, drop any pending write, set im_addr=0x0000_3000, count=0, err=0 and state=IDLE; clear SHALL take priority over a simultaneous accept or completion.
REQ-027 The address SHALL not wrap: the maximum written address is 0x0000_3FFC.

Reset
REQ-028 On reset=0 at a clock edge, the block SHALL set state=IDLE, im_we=0, im_addr=0x0000_3000, im_wdata=0, count=0, full=0 and err=0.
REQ-029 A pending write SHALL be discarded by reset.
REQ-030 in_ready SHALL be 0 while reset=0.

Structure
REQ-031 The instr_type codes, the opcode/funct constants, the base address 0x3000 and the capacity 1024 SHALL live in a shared package also used by CU.
REQ-032 The word encoding SHALL be one combinational sub-module, instr_pack (type plus fields in, word plus valid-flag out); the FSM and handshake SHALL stay in instr_encoder.

Verification
REQ-033 Reset then add rs=1, rt=2, rd=3 with im_ready=1 -> next cycle im_we=1, im_addr=0x3000, im_wdata=0x00221820; count=1 after completion.
REQ-034 ori rs=0, rt=8, imm=0x1234 then lui rt=9, imm=0xFFFF back-to-back -> words 0x34081234 @0x3000 and 0x3C09FFFF @0x3004 on consecutive cycles.
REQ-035 Issue jal target=0xC00 while im_ready is held 0 for 3 cycles -> im_wdata=0x0C000C00 stable, in_ready=0, and a second request waits until the write completes.
REQ-036 in_type=0x55 -> err=1, im_we stays 0, count unchanged; a following beq rs=1, rt=1, imm=0xFFFF yields 0x1021FFFF.
REQ-037 Write 1024 nops -> full=1 and in_ready=0 with last address 0x3FFC; then clear -> full=0, count=0, next write goes to 0x3000.
REQ-038 Assert reset=0 while a write is pending -> im_we=0 after the edge and no write occurs.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared instruction-set constants: instr_type codes, MIPS opcode/funct
// fields, instruction-memory window and encoder FSM states.
package instr_encoder_pkg;

    // Instruction codes exchanged between the control unit and the encoder
    typedef enum logic [7:0] {
        IT_ADD = 8'h80,
        IT_SUB = 8'h81,
        IT_ORI = 8'h82,
        IT_LUI = 8'h83,
        IT_LW  = 8'h84,
        IT_SW  = 8'h85,
        IT_BEQ = 8'h86,
        IT_JAL = 8'h87,
        IT_JR  = 8'h88,
        IT_NOP = 8'h89
    } instr_type_e;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Instruction memory window written by the encoder
    localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
    localparam logic [10:0] IM_CAPACITY  = 11'd1024;

    // Encoder write-sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: instruction code plus register/immediate/target
// fields in, 32-bit machine word and a "known code" flag out.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [7:0]  instr_type,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        known
);

    // Select the field layout for the requested instruction
    always_comb begin
        word  = 32'h0000_0000;
        known = 1'b1;
        case (instr_type_e'(instr_type))
            IT_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_ADD};
            IT_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_SUB};
            IT_ORI:  word = {OP_ORI, rs, rt, imm};
            IT_LUI:  word = {OP_LUI, 5'b00000, rt, imm};
            IT_LW:   word = {OP_LW, rs, rt, imm};
            IT_SW:   word = {OP_SW, rs, rt, imm};
            IT_BEQ:  word = {OP_BEQ, rs, rt, imm};
            IT_JAL:  word = {OP_JAL, target};
            IT_JR:   word = {OP_RTYPE, rs, 15'b0, FN_JR};
            IT_NOP:  word = 32'h0000_0000;
            default: begin
                word  = 32'h0000_0000;
                known = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts encode requests, packs them into machine
// words and writes them sequentially into instruction memory starting at
// the base address, one word per cycle when memory keeps up.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_type,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        im_we,
    input  logic        im_ready,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    input  logic        clear,
    output logic        full,
    output logic        err,
    output logic [10:0] count
);

    enc_state_e  state_r, state_s;
    logic        we_r, we_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic [10:0] count_r, count_s;
    logic        err_r, err_s;
    logic        full_r;
    logic [31:0] pack_word_s;
    logic        pack_known_s;
    logic        ready_s;
    logic        accept_s;
    logic        complete_s;

    instr_pack u_pack (
        .instr_type (in_type),
        .rs         (in_rs),
        .rt         (in_rt),
        .rd         (in_rd),
        .imm        (in_imm),
        .target     (in_target),
        .word       (pack_word_s),
        .known      (pack_known_s)
    );

    // Handshake decode and next-state / next-datapath computation
    always_comb begin
        ready_s    = reset && (!we_r || im_ready) && (state_r != ST_FULL) && !clear;
        accept_s   = in_valid && ready_s;
        complete_s = we_r && im_ready;
        state_s    = state_r;
        we_s       = we_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        count_s    = count_r;
        err_s      = err_r;
        if (clear) begin
            we_s    = 1'b0;
            addr_s  = IM_BASE_ADDR;
            count_s = 11'd0;
            err_s   = 1'b0;
            state_s = ST_IDLE;
        end else begin
            if (complete_s) begin
                we_s    = 1'b0;
                count_s = count_r + 11'd1;
                // The final slot's address is held so the pointer never
                // leaves the instruction-memory window.
                if (count_s != IM_CAPACITY) begin
                    addr_s = addr_r + 32'd4;
                end else begin
                    addr_s = addr_r;
                end
            end else begin
                count_s = count_r;
            end
            if (accept_s) begin
                if (!pack_known_s) begin
                    err_s = 1'b1;
                end else if (count_s == IM_CAPACITY) begin
                    // Request taken alongside the completion that fills
                    // memory: there is no slot left, so it is dropped.
                    we_s = 1'b0;
                end else begin
                    we_s    = 1'b1;
                    wdata_s = pack_word_s;
                end
            end else begin
                we_s = we_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (complete_s) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (count_s == IM_CAPACITY) begin
                        state_s = ST_FULL;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_FULL: state_s = ST_FULL;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            we_r    <= 1'b0;
            addr_r  <= IM_BASE_ADDR;
            wdata_r <= 32'h0000_0000;
            count_r <= 11'd0;
            err_r   <= 1'b0;
            full_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            count_r <= count_s;
            err_r   <= err_s;
            full_r  <= (state_s == ST_FULL);
        end
    end

    assign in_ready = ready_s;
    assign im_we    = we_r;
    assign im_addr  = addr_r;
    assign im_wdata = wdata_r;
    assign count    = count_r;
    assign err      = err_r;
    assign full     = full_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_type;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        im_we;
    logic        im_ready;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        clear;
    logic        full;
    logic        err;
    logic [10:0] count;

    int checks   = 0;
    int failures = 0;

    instr_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .in_target (in_target),
        .im_we     (im_we),
        .im_ready  (im_ready),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .clear     (clear),
        .full      (full),
        .err       (err),
        .count     (count)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [7:0] t, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        in_valid  = 1'b1;
        in_type   = t;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = tgt;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_type = 8'h89; in_rs = 5'd0; in_rt = 5'd0;
        in_rd = 5'd0; in_imm = 16'h0; in_target = 26'h0; im_ready = 1'b1; clear = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_we",    {31'd0, im_we}, 32'd0);
        check("rst_addr",  im_addr, 32'h0000_3000);
        check("rst_wdata", im_wdata, 32'h0000_0000);
        check("rst_count", {21'd0, count}, 32'd0);
        check("rst_full",  {31'd0, full}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);

        // add rs=1 rt=2 rd=3
        reset = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);
        req(8'h80, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        in_valid = 1'b0;
        check("add_we",    {31'd0, im_we}, 32'd1);
        check("add_addr",  im_addr, 32'h0000_3000);
        check("add_word",  im_wdata, 32'h0022_1820);
        check("add_cnt0",  {21'd0, count}, 32'd0);
        tick();
        check("add_cnt1",  {21'd0, count}, 32'd1);
        check("add_done",  {31'd0, im_we}, 32'd0);
        check("add_adv",   im_addr, 32'h0000_3004);

        // clear restarts the address counter
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_addr",  im_addr, 32'h0000_3000);
        check("clr_count", {21'd0, count}, 32'd0);

        // ori then lui back-to-back
        req(8'h82, 5'd0, 5'd8, 5'd0, 16'h1234, 26'h0);
        tick();
        check("ori_word",  im_wdata, 32'h3408_1234);
        check("ori_addr",  im_addr, 32'h0000_3000);
        req(8'h83, 5'd0, 5'd9, 5'd0, 16'hFFFF, 26'h0);
        #1;
        check("b2b_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("lui_we",    {31'd0, im_we}, 32'd1);
        check("lui_word",  im_wdata, 32'h3C09_FFFF);
        check("lui_addr",  im_addr, 32'h0000_3004);
        check("lui_cnt",   {21'd0, count}, 32'd1);
        tick();
        check("b2b_cnt",   {21'd0, count}, 32'd2);
        check("b2b_addr",  im_addr, 32'h0000_3008);

        // jal held by im_ready=0; second request must wait
        im_ready = 1'b0;
        req(8'h87, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0C00);
        tick();
        req(8'h80, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        for (int i = 0; i < 3; i++) begin
            check("jal_word",  im_wdata, 32'h0C00_0C00);
            check("jal_we",    {31'd0, im_we}, 32'd1);
            check("jal_rdy0",  {31'd0, in_ready}, 32'd0);
            check("jal_addr",  im_addr, 32'h0000_3008);
            tick();
        end
        im_ready = 1'b1;
        #1;
        check("jal_rdy1",  {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("wait_cnt",  {21'd0, count}, 32'd3);
        check("wait_addr", im_addr, 32'h0000_300C);
        check("wait_word", im_wdata, 32'h0022_1820);
        tick();
        check("wait_cnt2", {21'd0, count}, 32'd4);

        // Unknown type then beq
        req(8'h55, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        tick();
        check("unk_err",   {31'd0, err}, 32'd1);
        check("unk_we",    {31'd0, im_we}, 32'd0);
        check("unk_cnt",   {21'd0, count}, 32'd4);
        check("unk_addr",  im_addr, 32'h0000_3010);
        req(8'h86, 5'd1, 5'd1, 5'd0, 16'hFFFF, 26'h0);
        tick();
        in_valid = 1'b0;
        check("beq_word",  im_wdata, 32'h1021_FFFF);
        check("beq_addr",  im_addr, 32'h0000_3010);
        check("err_stick", {31'd0, err}, 32'd1);
        tick();
        check("beq_cnt",   {21'd0, count}, 32'd5);

        // Reset while a write is pending
        im_ready = 1'b0;
        req(8'h81, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        tick();
        in_valid = 1'b0;
        check("sub_word",  im_wdata, 32'h0085_3022);
        check("sub_we",    {31'd0, im_we}, 32'd1);
        reset = 1'b0;
        tick();
        check("rstp_we",   {31'd0, im_we}, 32'd0);
        check("rstp_cnt",  {21'd0, count}, 32'd0);
        check("rstp_addr", im_addr, 32'h0000_3000);
        check("rstp_err",  {31'd0, err}, 32'd0);
        check("rstp_rdy",  {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        im_ready = 1'b1;
        tick();
        check("rstp_nowr", {31'd0, im_we}, 32'd0);
        check("rstp_cnt2", {21'd0, count}, 32'd0);

        // Fill memory with 1024 nops
        req(8'h89, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        for (int i = 0; i < 1024; i++) begin
            tick();
        end
        in_valid = 1'b0;
        check("last_addr", im_addr, 32'h0000_3FFC);
        check("last_we",   {31'd0, im_we}, 32'd1);
        check("last_cnt",  {21'd0, count}, 32'd1023);
        check("pre_full",  {31'd0, full}, 32'd0);
        tick();
        check("full",      {31'd0, full}, 32'd1);
        check("full_cnt",  {21'd0, count}, 32'd1024);
        check("full_we",   {31'd0, im_we}, 32'd0);
        req(8'h89, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        #1;
        check("full_rdy",  {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("full_nowr", {31'd0, im_we}, 32'd0);
        check("full_hold", {21'd0, count}, 32'd1024);

        // Clear out of FULL, then write jr
        clear = 1'b1;
        #1;
        check("clr_rdy",   {31'd0, in_ready}, 32'd0);
        tick();
        clear = 1'b0;
        check("clr_full",  {31'd0, full}, 32'd0);
        check("clr_cnt",   {21'd0, count}, 32'd0);
        check("clr_addr2", im_addr, 32'h0000_3000);
        req(8'h88, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0);
        tick();
        in_valid = 1'b0;
        check("jr_addr",   im_addr, 32'h0000_3000);
        check("jr_word",   im_wdata, 32'h03E0_0008);
        tick();
        check("jr_cnt",    {21'd0, count}, 32'd1);

        // Clear beats a simultaneous completion
        im_ready = 1'b0;
        req(8'h84, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0);
        tick();
        in_valid = 1'b0;
        check("lw_word",   im_wdata, 32'h8C43_0010);
        im_ready = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clrp_we",   {31'd0, im_we}, 32'd0);
        check("clrp_cnt",  {21'd0, count}, 32'd0);
        check("clrp_addr", im_addr, 32'h0000_3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
